if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the ARM pipeline. Sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Holds one fetched instruction in a single-entry buffer until the downstream stage takes it.
- Redirects the PC on taken branches reported by EXE.

---
 rtl/if_fetch_stage.sv | 96 +++++++++
 tb/tb_if_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake and holds one
// fetched instruction until the downstream IF/ID register takes it.
module if_fetch_stage #(
    parameter int unsigned ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_ready,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0] PC,
    output logic [ADDRESS_LEN-1:0] Instruction,
    output logic                   fetch_stall
);

    typedef enum logic [0:0] {
        StFetch,
        StDiscard
    } state_e;

    localparam logic [ADDRESS_LEN-1:0] WordMask = ADDRESS_LEN'(3);
    localparam logic [ADDRESS_LEN-1:0] WordStep = ADDRESS_LEN'(4);

    state_e                 state_q;
    logic [ADDRESS_LEN-1:0] pc_q;
    logic [ADDRESS_LEN-1:0] redirect_q;
    logic [ADDRESS_LEN-1:0] buf_instr_q;
    logic [ADDRESS_LEN-1:0] buf_pc_q;
    logic                   valid_q;

    logic [ADDRESS_LEN-1:0] branch_target;
    logic [ADDRESS_LEN-1:0] pc_plus4;
    logic                   fetch_done;
    logic                   consume;

    always_comb begin
        branch_target = branch_address & ~WordMask;
        pc_plus4      = pc_q + WordStep;
        imem_req      = (state_q == StDiscard) | ~valid_q | ~freeze;
        imem_addr     = pc_q;
        fetch_done    = imem_req & imem_ready;
        consume       = valid_q & ~freeze;
        PC            = valid_q ? buf_pc_q : '0;
        Instruction   = valid_q ? buf_instr_q : '0;
        fetch_stall   = ~valid_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            redirect_q  <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (branch_taken) begin
                        valid_q <= 1'b0;
                        // A stalled request must keep its address, so park the target instead.
                        if (imem_req && !imem_ready) begin
                            state_q    <= StDiscard;
                            redirect_q <= branch_target;
                        end else begin
                            pc_q <= branch_target;
                        end
                    end else if (fetch_done) begin
                        buf_instr_q <= imem_rdata;
                        buf_pc_q    <= pc_plus4;
                        valid_q     <= 1'b1;
                        pc_q        <= pc_plus4;
                    end else if (consume) begin
                        valid_q <= 1'b0;
                    end
                end
                StDiscard: begin
                    if (branch_taken) begin
                        redirect_q <= branch_target;
                    end
                    if (imem_ready) begin
                        pc_q    <= branch_taken ? branch_target : redirect_q;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage: a transaction-level model (fetch pointer, pending
// redirect, one-entry queue) predicts every output each cycle; directed phases cover the corners.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_stall;

    // Second instance checks PC wrap from a reset vector at the top of the address space.
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_stall;

    bit scramble;
    int checks;
    int failures;

    if_fetch_stage #(
        .ADDRESS_LEN(32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .PC            (PC),
        .Instruction   (Instruction),
        .fetch_stall   (fetch_stall)
    );

    if_fetch_stage #(
        .ADDRESS_LEN(32),
        .RESET_PC   (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .freeze        (1'b0),
        .branch_taken  (1'b0),
        .branch_address(32'h0),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ready    (1'b1),
        .imem_rdata    (w_rdata),
        .PC            (w_pc),
        .Instruction   (w_instr),
        .fetch_stall   (w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit scr);
        return scr ? ((a * 32'h9E37_79B1) ^ 32'h0000_1234) : a;
    endfunction

    always_comb begin
        imem_rdata = mem_word(imem_addr, scramble);
        w_rdata    = w_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_buf[$];
    logic [31:0] m_fetch_addr;
    bit          m_pending;
    logic [31:0] m_target;
    bit          hold_prev;
    logic [31:0] hold_addr;

    task automatic model_reset();
        m_buf.delete();
        m_fetch_addr = 32'h0;
        m_pending    = 1'b0;
        m_target     = 32'h0;
        hold_prev    = 1'b0;
    endtask

    function automatic bit model_req(input logic f);
        return m_pending || (m_buf.size() == 0) || !f;
    endfunction

    task automatic model_update(input logic f, input logic b, input logic [31:0] ba,
                                input logic r);
        bit          req;
        logic [31:0] tgt;
        req = model_req(f);
        tgt = {ba[31:2], 2'b00};
        if (b) begin
            m_buf.delete();
            if (m_pending) begin
                m_target = tgt;
                if (r) begin
                    m_fetch_addr = tgt;
                    m_pending    = 1'b0;
                end
            end else if (req && !r) begin
                m_pending = 1'b1;
                m_target  = tgt;
            end else begin
                m_fetch_addr = tgt;
            end
        end else if (m_pending) begin
            if (r) begin
                m_fetch_addr = m_target;
                m_pending    = 1'b0;
            end
        end else begin
            if (m_buf.size() == 1 && !f) void'(m_buf.pop_front());
            if (req && r) begin
                m_buf.delete();
                m_buf.push_back('{instr: mem_word(m_fetch_addr, scramble),
                                  pc: m_fetch_addr + 32'd4});
                m_fetch_addr = m_fetch_addr + 32'd4;
            end
        end
    endtask

    task automatic check_outputs(input logic f);
        bit has;
        has = (m_buf.size() == 1);
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, model_req(f)});
        check_eq("imem_addr", imem_addr, m_fetch_addr);
        check_eq("Instruction", Instruction, has ? m_buf[0].instr : 32'h0);
        check_eq("PC", PC, has ? m_buf[0].pc : 32'h0);
        check_eq("fetch_stall", {31'b0, fetch_stall}, {31'b0, !has});
        if (hold_prev) begin
            check_eq("hs_req_hold", {31'b0, imem_req}, 32'h1);
            check_eq("hs_addr_hold", imem_addr, hold_addr);
        end
    endtask

    // Called at a negedge: drive, check before the edge, advance model at the edge.
    task automatic step(input logic f, input logic b, input logic [31:0] ba, input logic r);
        bit          req;
        logic [31:0] addr;
        freeze         = f;
        branch_taken   = b;
        branch_address = ba;
        imem_ready     = r;
        #2;
        check_outputs(f);
        req  = model_req(f);
        addr = m_fetch_addr;
        @(posedge clk);
        model_update(f, b, ba, r);
        hold_prev = req && !r;
        hold_addr = addr;
        @(negedge clk);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        scramble       = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        imem_ready     = 1'b0;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_instr", Instruction, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        rst = 1'b1;

        // Streaming from reset, rdata equals address.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stream_i0", Instruction, 32'h0);
        check_eq("stream_v0", {31'b0, fetch_stall}, 32'h0);
        check_eq("stream_pc0", PC, 32'h4);
        check_eq("wrap_addr", w_addr, 32'h0);
        check_eq("wrap_instr", w_instr, 32'hFFFF_FFFC);
        check_eq("wrap_pc", w_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stream_i1", Instruction, 32'h4);
        check_eq("wrap_addr2", w_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stream_i2", Instruction, 32'h8);
        check_eq("stream_pc2", PC, 32'hC);

        // Freeze while holding an instruction.
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("freeze_hold_i", Instruction, 32'h8);
        check_eq("freeze_addr", imem_addr, 32'hC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("unfreeze_i", Instruction, 32'hC);

        // Branch with memory ready.
        step(1'b0, 1'b1, 32'h100, 1'b1);
        check_eq("br_bubble", Instruction, 32'h0);
        check_eq("br_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("br_instr", Instruction, 32'h100);
        check_eq("br_pc", PC, 32'h104);

        // Branch while a request to 0x8 is stalled.
        step(1'b0, 1'b1, 32'h8, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("disc_addr_hold", imem_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("disc_redirect", imem_addr, 32'h200);
        check_eq("disc_dropped", Instruction, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("disc_next", Instruction, 32'h200);

        // Target alignment.
        step(1'b0, 1'b1, 32'h103, 1'b1);
        check_eq("align_addr", imem_addr, 32'h100);

        // Randomised traffic.
        scramble = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom, ($urandom % 3) != 0);
        end

        // Asynchronous reset between edges while valid and frozen.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("pre_arst_valid", {31'b0, fetch_stall}, 32'h0);
        #3 rst = 1'b0;
        #1;
        check_eq("arst_pc", PC, 32'h0);
        check_eq("arst_instr", Instruction, 32'h0);
        check_eq("arst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
